// File: rtl/cmp4_pkg.sv
// Shared definitions for the comparator4-based window statistics stage.
package cmp4_pkg;

  localparam int SAMPLE_W = 4;

  typedef enum logic {
    FILL   = 1'b0,
    REPORT = 1'b1
  } state_e;

  // Smallest count width w with 2**w > win, so a count of win-1 never wraps.
  function automatic int min_cnt_w(input int win);
    int w;
    w = 1;
    while ((1 << w) <= win) w++;
    return w;
  endfunction

endpackage

// File: rtl/cmp4_window_stats_if.sv
// Sample input and window report handshakes of the window statistics stage.
interface cmp4_window_stats_if #(parameter int CNT_W = 5);
  import cmp4_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [0:SAMPLE_W-1] in_data;
  logic                out_valid;
  logic                out_ready;
  logic [0:SAMPLE_W-1] max_val;
  logic [0:SAMPLE_W-1] min_val;
  logic [CNT_W-1:0]    cnt_rise;
  logic [CNT_W-1:0]    cnt_fall;
  logic [CNT_W-1:0]    cnt_eq;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, max_val, min_val, cnt_rise, cnt_fall, cnt_eq
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, max_val, min_val, cnt_rise, cnt_fall, cnt_eq
  );

endinterface

// File: rtl/comparator4.sv
// Unsigned 4-bit magnitude comparator; bit 0 of each operand is the MSB.
module comparator4 (
  input  logic [0:3] a,
  input  logic [0:3] b,
  output logic       g,
  output logic       e,
  output logic       l
);

  assign g = (a > b);
  assign e = (a == b);
  assign l = (a < b);

endmodule

// File: rtl/cmp4_window_stats.sv
// Windowed max/min and rise/fall/equal statistics over a stream of 4-bit samples.
module cmp4_window_stats
  import cmp4_pkg::*;
#(
  parameter int WIN   = 16,
  parameter int CNT_W = 5
) (
  input logic                clk,
  input logic                rst,
  input logic                clr,
  cmp4_window_stats_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIN - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_e              state;
  logic [0:SAMPLE_W-1] prev, max_q, min_q;
  logic [CNT_W-1:0]    idx, rise_q, fall_q, eq_q;
  logic                first, valid_q;
  logic                gt_prev, eq_prev, lt_prev;
  logic                gt_max, eq_max, lt_max;
  logic                gt_min, eq_min, lt_min;
  logic                accept;

  comparator4 u_cmp_prev (.a(bus.in_data), .b(prev),  .g(gt_prev), .e(eq_prev), .l(lt_prev));
  comparator4 u_cmp_max  (.a(bus.in_data), .b(max_q), .g(gt_max),  .e(eq_max),  .l(lt_max));
  comparator4 u_cmp_min  (.a(bus.in_data), .b(min_q), .g(gt_min),  .e(eq_min),  .l(lt_min));

  // Gated by rst so the source sees no ready while the stage is held in reset.
  assign bus.in_ready  = (state == FILL) && !rst;
  assign accept        = bus.in_valid && (state == FILL);
  assign bus.out_valid = valid_q;
  assign bus.max_val   = max_q;
  assign bus.min_val   = min_q;
  assign bus.cnt_rise  = rise_q;
  assign bus.cnt_fall  = fall_q;
  assign bus.cnt_eq    = eq_q;

  // NOTE: every state register uses <= so all updates see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FILL;
      prev    <= '0;
      max_q   <= '0;
      min_q   <= '0;
      idx     <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      eq_q    <= '0;
      first   <= 1'b1;
      valid_q <= 1'b0;
    end else if (clr) begin
      state   <= FILL;
      idx     <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      eq_q    <= '0;
      first   <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            if (first) begin
              max_q <= bus.in_data;
              min_q <= bus.in_data;
              first <= 1'b0;
            end else begin
              if (gt_prev) rise_q <= rise_q + ONE;
              if (eq_prev) eq_q   <= eq_q + ONE;
              if (lt_prev) fall_q <= fall_q + ONE;
              if (gt_max)  max_q  <= bus.in_data;
              if (lt_min)  min_q  <= bus.in_data;
            end
            prev <= bus.in_data;
            // The last sample's updates land on the same edge that raises the report.
            if (idx == LAST_IDX) begin
              state   <= REPORT;
              valid_q <= 1'b1;
            end else begin
              idx <= idx + ONE;
            end
          end
        end
        REPORT: begin
          if (bus.out_ready) begin
            state   <= FILL;
            valid_q <= 1'b0;
            idx     <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            eq_q    <= '0;
            first   <= 1'b1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp4_window_stats.sv
// Drives WIN=4 and WIN=16 instances with directed and random windows against a queue-based model.
module tb_cmp4_window_stats;
  import cmp4_pkg::*;

  typedef struct {
    int mx;
    int mn;
    int rise;
    int fall;
    int eq;
  } rep_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic v = 1'b0;
  logic ordy = 1'b0;
  logic [0:3] d = '0;
  int sel = 0;
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  cmp4_window_stats_if #(.CNT_W(3)) if4 ();
  cmp4_window_stats_if #(.CNT_W(5)) if16 ();

  assign if4.in_valid   = v && (sel == 0);
  assign if16.in_valid  = v && (sel == 1);
  assign if4.in_data    = d;
  assign if16.in_data   = d;
  assign if4.out_ready  = ordy && (sel == 0);
  assign if16.out_ready = ordy && (sel == 1);

  cmp4_window_stats #(.WIN(4),  .CNT_W(3)) dut4  (.clk(clk), .rst(rst), .clr(clr), .bus(if4));
  cmp4_window_stats #(.WIN(16), .CNT_W(5)) dut16 (.clk(clk), .rst(rst), .clr(clr), .bus(if16));

  logic       o_valid, i_ready;
  logic [0:3] o_max, o_min;
  logic [4:0] o_rise, o_fall, o_eq;

  assign o_valid = (sel == 1) ? if16.out_valid : if4.out_valid;
  assign i_ready = (sel == 1) ? if16.in_ready  : if4.in_ready;
  assign o_max   = (sel == 1) ? if16.max_val   : if4.max_val;
  assign o_min   = (sel == 1) ? if16.min_val   : if4.min_val;
  assign o_rise  = (sel == 1) ? if16.cnt_rise  : {2'b00, if4.cnt_rise};
  assign o_fall  = (sel == 1) ? if16.cnt_fall  : {2'b00, if4.cnt_fall};
  assign o_eq    = (sel == 1) ? if16.cnt_eq    : {2'b00, if4.cnt_eq};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Window statistics straight from their definition over the whole sample list.
  function automatic rep_t model(input int q[$]);
    rep_t r;
    r.mx = q[0];
    r.mn = q[0];
    r.rise = 0;
    r.fall = 0;
    r.eq = 0;
    for (int i = 1; i < q.size(); i++) begin
      if (q[i] > r.mx) r.mx = q[i];
      if (q[i] < r.mn) r.mn = q[i];
      if (q[i] > q[i-1]) r.rise++;
      else if (q[i] < q[i-1]) r.fall++;
      else r.eq++;
    end
    return r;
  endfunction

  task automatic push(input int s);
    int n;
    n = 0;
    @(negedge clk);
    v = 1'b1;
    d = 4'(s);
    while (i_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (i_ready !== 1'b1) check("push_ready_timeout", {31'b0, i_ready}, 1);
    @(posedge clk);
    #1 v = 1'b0;
  endtask

  task automatic push_all(input int q[$], input bit gaps);
    foreach (q[i]) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      push(q[i]);
    end
  endtask

  task automatic check_fields(input string tag, input rep_t e);
    check({tag, "_max"},  32'(o_max),  e.mx);
    check({tag, "_min"},  32'(o_min),  e.mn);
    check({tag, "_rise"}, 32'(o_rise), e.rise);
    check({tag, "_fall"}, 32'(o_fall), e.fall);
    check({tag, "_eq"},   32'(o_eq),   e.eq);
  endtask

  task automatic expect_report(input string tag, input rep_t e, input int win);
    int n;
    n = 0;
    while (o_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, {31'b0, o_valid}, 1);
    check_fields(tag, e);
    check({tag, "_sum"}, 32'(o_rise) + 32'(o_fall) + 32'(o_eq), win - 1);
    @(negedge clk);
    ordy = 1'b1;
    @(posedge clk);
    #1 ordy = 1'b0;
    check({tag, "_valid_drop"}, {31'b0, o_valid}, 0);
    check({tag, "_cleared"}, 32'(o_rise) + 32'(o_fall) + 32'(o_eq), 0);
    check({tag, "_ready_after"}, {31'b0, i_ready}, 1);
  endtask

  task automatic run_window(input string tag, input int q[$], input int win, input bit gaps);
    push_all(q, gaps);
    expect_report(tag, model(q), win);
  endtask

  initial begin
    int q[$];
    rep_t e;

    // Reset state.
    #1;
    check("rst_ready", {31'b0, i_ready}, 0);
    check("rst_valid", {31'b0, o_valid}, 0);
    check("rst_max", 32'(o_max), 0);
    check("rst_cnt", 32'(o_rise) + 32'(o_fall) + 32'(o_eq), 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rst_release_ready", {31'b0, i_ready}, 1);

    // 3,7,7,2 with exact report latency.
    sel = 0;
    push_all('{3, 7, 7}, 1'b0);
    @(negedge clk);
    check("lat_before", {31'b0, o_valid}, 0);
    push(2);
    check("lat_after", {31'b0, o_valid}, 1);
    e = '{mx: 7, mn: 2, rise: 1, fall: 1, eq: 1};
    expect_report("w3772", e, 4);

    e = '{mx: 0, mn: 0, rise: 0, fall: 0, eq: 3};
    push_all('{0, 0, 0, 0}, 1'b0);
    expect_report("w0000", e, 4);

    // Ascending then descending on the 16-sample instance.
    sel = 1;
    q = {};
    for (int i = 0; i < 16; i++) q.push_back(i);
    push_all(q, 1'b0);
    e = '{mx: 15, mn: 0, rise: 15, fall: 0, eq: 0};
    expect_report("asc", e, 16);
    q = {};
    for (int i = 15; i >= 0; i--) q.push_back(i);
    push_all(q, 1'b0);
    e = '{mx: 15, mn: 0, rise: 0, fall: 15, eq: 0};
    expect_report("desc", e, 16);

    // Backpressure: report must hold while in_valid keeps toggling data.
    sel = 0;
    q = '{1, 9, 4, 4};
    push_all(q, 1'b0);
    e = model(q);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      v = 1'b1;
      d = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
      check("bp_ready", {31'b0, i_ready}, 0);
      check("bp_valid", {31'b0, o_valid}, 1);
      check_fields("bp", e);
    end
    v = 1'b0;
    expect_report("bp_rel", e, 4);
    run_window("bp_next", '{6, 2, 8, 8}, 4, 1'b0);

    // clr on the same edge as a sample: that sample is dropped.
    push_all('{9, 1}, 1'b0);
    @(negedge clk);
    v = 1'b1;
    d = 4'd3;
    clr = 1'b1;
    @(posedge clk);
    #1;
    v = 1'b0;
    clr = 1'b0;
    check("clr_valid", {31'b0, o_valid}, 0);
    check("clr_cnt", 32'(o_rise) + 32'(o_fall) + 32'(o_eq), 0);
    e = '{mx: 5, mn: 5, rise: 0, fall: 0, eq: 3};
    push_all('{5, 5, 5, 5}, 1'b0);
    expect_report("clr_next", e, 4);

    // Asynchronous reset in the middle of a cycle mid-window.
    push_all('{12, 3}, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_ready", {31'b0, i_ready}, 0);
    check("arst_valid", {31'b0, o_valid}, 0);
    check("arst_max", 32'(o_max), 0);
    check("arst_min", 32'(o_min), 0);
    check("arst_cnt", 32'(o_rise) + 32'(o_fall) + 32'(o_eq), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("arst_release_ready", {31'b0, i_ready}, 1);
    e = '{mx: 15, mn: 0, rise: 1, fall: 2, eq: 0};
    push_all('{15, 0, 15, 0}, 1'b0);
    expect_report("arst_next", e, 4);

    // Random windows on both instances, with random idle gaps.
    for (int w = 0; w < 6; w++) begin
      sel = w % 2;
      q = {};
      for (int i = 0; i < ((sel == 1) ? 16 : 4); i++) q.push_back($urandom_range(0, 15));
      run_window($sformatf("rnd%0d", w), q, (sel == 1) ? 16 : 4, 1'b1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
